// File: rtl/display_scan_driver_if.sv
// Digit-stream write side and scanned display side of display_scan_driver.
// The producer of digits/commits uses master; the scan driver uses slave.
interface display_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    // digit_valid and commit are single-cycle strobes sampled on every rising
    // clock edge; there is no back-pressure, the driver accepts them every cycle.
    logic [3:0]            digit;
    logic [1:0]            digit_place;
    logic                  digit_valid;
    logic                  commit;
    logic [3:0]            scan_digit;
    logic [1:0]            scan_place;
    logic [NUM_DIGITS-1:0] anode;
    logic                  frame_tick;

    modport master (
        output digit, digit_place, digit_valid, commit,
        input  scan_digit, scan_place, anode, frame_tick
    );

    modport slave (
        input  digit, digit_place, digit_valid, commit,
        output scan_digit, scan_place, anode, frame_tick
    );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: staging/display buffers,
// per-slot refresh timing with dead-time, and leading-zero blanking.
module display_scan_driver #(
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYCLES = 16
) (
    input logic                  clock,
    input logic                  reset_n,
    display_scan_driver_if.slave bus
);
    localparam int             TW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0]  TICK_LIT   = TW'(DEAD_CYCLES);
    localparam logic [1:0]     POS_LAST   = 2'(NUM_DIGITS - 1);

    logic [3:0]            staging      [NUM_DIGITS];
    logic [3:0]            staging_next [NUM_DIGITS];
    logic [3:0]            display      [NUM_DIGITS];
    logic [TW-1:0]         tick_cnt;
    logic [1:0]            scan_pos;
    logic [NUM_DIGITS-1:0] blanked;
    logic                  zero_run;

    // The same-cycle write is folded in before commit so commit writes through.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            staging_next[i] = staging[i];
            if (bus.digit_valid && int'(bus.digit_place) == i) begin
                staging_next[i] = bus.digit;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                staging[i] <= '0;
                display[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                staging[i] <= staging_next[i];
                if (bus.commit) begin
                    display[i] <= staging_next[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            scan_pos <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            scan_pos <= (scan_pos == POS_LAST) ? 2'd0 : scan_pos + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A slot is blank when it and every more-significant slot hold zero.
    always_comb begin
        blanked  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (display[k] == 4'd0);
            blanked[k] = zero_run;
        end
    end

    always_comb begin
        bus.scan_digit = '0;
        bus.anode      = '0;
        bus.scan_place = scan_pos;
        bus.frame_tick = (tick_cnt == TICK_LAST) && (scan_pos == POS_LAST);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(scan_pos) == i) begin
                bus.scan_digit = display[i];
                bus.anode[i]   = (tick_cnt >= TICK_LIT) && !blanked[i];
            end
        end
    end
endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
Consumes the digit stream from binary_to_bcd (one BCD digit plus its place per write) and drives a time-multiplexed common-anode 7-segment display. Digits are collected in a staging buffer and copied to a display buffer on commit. The scanner then refreshes one digit slot at a time, with dead-time between slots and leading-zero blanking. scan_digit feeds seven_segment_decode_decimal; anode drives the digit-select pins.

Parameters:
NUM_DIGITS, 3, number of digit slots / places (place 0 = units); valid range 2..4.
REFRESH_DIV, 1024, clock cycles per slot; must be at least DEAD_CYCLES+2.
DEAD_CYCLES, 16, cycles at the start of each slot during which all anodes are off.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
digit  input  4  digit value from binary_to_bcd.
digit_place  input  2  slot index for digit.
digit_valid  input  1  write strobe; when high, digit is written to staging[digit_place].
commit  input  1  single-cycle pulse; copies the staging buffer to the display buffer.
scan_digit  output  4  display-buffer value of the slot currently scanned.
scan_place  output  2  index of the slot currently scanned.
anode  output  NUM_DIGITS  one-hot active-high slot enable; all zero during dead-time or when the slot is blanked.
frame_tick  output  1  one-cycle pulse on the last cycle of slot NUM_DIGITS-1.

Behaviour:
- Reset (async assert, sync release): staging and display buffers = 0; scan_pos = 0; tick_cnt = 0; outputs scan_digit = 0, scan_place = 0, anode = 0, frame_tick = 0.
- Write path: on digit_valid, staging[digit_place] <= digit.
  - digit_place >= NUM_DIGITS: write ignored, no state change.
  - Values 10..15 are stored and displayed unchanged; no range checking.
- Commit: on commit, display <= staging, effective next cycle.
  - If digit_valid and commit occur in the same cycle, the committed image includes that write (write-through).
  - Commit never resets or disturbs the scan counters.
- Scan counter: tick_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, scan_pos advances by 1, wrapping from NUM_DIGITS-1 to 0.
  - Runs continuously from reset release; digit_valid and commit never stall it.
- frame_tick = 1 when tick_cnt == REFRESH_DIV-1 and scan_pos == NUM_DIGITS-1.
- Outputs are decoded from the registered scan_pos, tick_cnt and display buffer, with no extra latency:
  - scan_place = scan_pos.
  - scan_digit = display[scan_pos].
  - anode[scan_pos] = 1 iff tick_cnt >= DEAD_CYCLES and the slot is not blanked; all other anode bits = 0.
- Leading-zero blanking: slot k (k >= 1) is blanked iff display[j] == 0 for every j from k up to NUM_DIGITS-1. Slot 0 is never blanked, so a value of 0 shows a single "0".
- A commit in mid-slot changes scan_digit and the blanking result from the next cycle; the slot timing is unaffected.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); anode goes to 0 in the same instant.

Test Plan:
Bench uses NUM_DIGITS=3, REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset then idle 48 cycles -> scan_place sequence 0,1,2,0,… with 8 cycles each; anode = 001 for cycles 2..7 of slot 0 and 000 in slots 1 and 2 (both blanked); frame_tick pulses every 24 cycles.
- Write 5,2,1 to places 0,1,2, then commit -> slot 0 shows scan_digit 5 with anode 001 (tick 2..7), slot 1 shows 2 with anode 010, slot 2 shows 1 with anode 100.
- Load 0,0,1 ("100") -> none blanked. Then load 7,0,0 -> slots 1 and 2 anode 000, slot 0 shows 7.
- digit_valid with place 3 and digit 9, then commit -> display unchanged. Write place 1 = 4 in the same cycle as commit -> slot 1 shows 4 after commit.
- Commit at tick_cnt=4 of slot 0 while showing 5 (new value 8) -> scan_digit = 8 from the next cycle; slot ends at tick 7 as scheduled.
- Assert reset_n low during slot 2 with anode 100 -> anode = 000 immediately. After release: scan_place 0, scan_digit 0, anode 001 at tick 2.
